// File: rtl/vector_data_mem.sv
// vector_data_mem: R-lane CPU data memory with a byte-wide host preload/readback port.
// A LOAD/RUN/DONE phase machine hands the array to the CPU in RUN and to the host otherwise.
module vector_data_mem #(
  parameter int I = 32,
  parameter int N = 8,
  parameter int R = 6,
  parameter int DEPTH = 256,
  parameter int AW = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                end_flag,
  input  logic                mem_write,
  input  logic [I-1:0]        address,
  input  logic [R-1:0][N-1:0] write_data,
  output logic [R-1:0][N-1:0] read_data,
  input  logic                host_valid,
  input  logic                host_we,
  input  logic [AW-1:0]       host_addr,
  input  logic [N-1:0]        host_wdata,
  output logic                host_ready,
  output logic                host_rvalid,
  output logic [N-1:0]        host_rdata,
  output logic                running,
  output logic                addr_error
);
  localparam int MW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {LOAD, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [N-1:0] r_mem [DEPTH];
  logic [R-1:0][I-1:0] w_addr;
  logic [R-1:0] w_inr;
  logic w_run, w_xfer, w_hrd, w_hinr, w_cpu_we;
  logic r_rvalid, r_err;
  logic [N-1:0] r_rdata;
  // Lane addresses stay at full CPU width so nothing wraps before the bound check
  always_comb begin
    for (int k = 0; k < R; k++) begin
      w_addr[k] = address + I'(k);
      w_inr[k] = w_addr[k] < I'(DEPTH);
      read_data[k] = w_inr[k] ? r_mem[w_addr[k][MW-1:0]] : '0;
    end
  end
  assign w_run = r_state == RUN;
  assign w_cpu_we = w_run & mem_write;
  assign w_xfer = host_valid & host_ready;
  assign w_hrd = w_xfer & ~host_we;
  assign w_hinr = {1'b0, host_addr} < (AW+1)'(DEPTH);
  assign host_ready = ~reset & ~w_run;
  assign host_rvalid = r_rvalid;
  assign host_rdata = r_rdata;
  assign running = w_run;
  assign addr_error = r_err;
  // end_flag outranks start in RUN; start only matters outside RUN
  always_comb w_next = w_run ? (end_flag ? DONE : RUN) : (start ? RUN : r_state);
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= LOAD;
    else r_state <= w_next;
  always_ff @(posedge clk) begin
    for (int k = 0; k < R; k++)
      if (w_cpu_we && w_inr[k]) r_mem[w_addr[k][MW-1:0]] <= write_data[k];
    if (w_xfer && host_we && w_hinr) r_mem[host_addr[MW-1:0]] <= host_wdata;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rdata <= '0;
      r_err <= 1'b0;
    end else begin
      r_rvalid <= w_hrd;
      if (w_hrd) r_rdata <= w_hinr ? r_mem[host_addr[MW-1:0]] : '0;
      if ((w_run && !(&w_inr)) || (w_xfer && !w_hinr)) r_err <= 1'b1;
    end
endmodule

// File: tb/tb_vector_data_mem.sv
// tb_vector_data_mem: directed bench; host reads are scored through queues by negedge monitors.
module tb_vector_data_mem;
  logic clk = 0, reset = 1, start = 0, end_flag = 0, mem_write = 0;
  logic [31:0] address = '0;
  logic [5:0][7:0] write_data = '0, read_data, rd2;
  logic host_valid = 0, host_we = 0, host_ready, host_rvalid, running, addr_error;
  logic [7:0] host_addr = '0, host_wdata = '0, host_rdata;
  logic h2_valid = 0, h2_we = 0, h2_ready, h2_rvalid, run2, err2;
  logic [7:0] h2_addr = '0, h2_wdata = '0, h2_rdata;
  logic [7:0] q1[$], q2[$];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  vector_data_mem dut (
    .clk(clk), .reset(reset), .start(start), .end_flag(end_flag), .mem_write(mem_write),
    .address(address), .write_data(write_data), .read_data(read_data),
    .host_valid(host_valid), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ready(host_ready), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .running(running), .addr_error(addr_error));

  vector_data_mem #(.DEPTH(200)) dut2 (
    .clk(clk), .reset(reset), .start(1'b0), .end_flag(1'b0), .mem_write(1'b0),
    .address(32'd0), .write_data(48'd0), .read_data(rd2),
    .host_valid(h2_valid), .host_we(h2_we), .host_addr(h2_addr), .host_wdata(h2_wdata),
    .host_ready(h2_ready), .host_rvalid(h2_rvalid), .host_rdata(h2_rdata),
    .running(run2), .addr_error(err2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (host_rvalid) begin
      if (q1.size() == 0) chk("host_rvalid_unexpected", 1, 0);
      else chk("host_rdata", host_rdata, q1.pop_front());
    end

  always @(negedge clk)
    if (h2_rvalid) begin
      if (q2.size() == 0) chk("h2_rvalid_unexpected", 1, 0);
      else chk("h2_rdata", h2_rdata, q2.pop_front());
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
    host_valid = 1; host_we = 1; host_addr = a; host_wdata = d;
    tick();
    host_valid = 0; host_we = 0;
  endtask

  task automatic host_rd(input logic [7:0] a, input logic [7:0] exp);
    q1.push_back(exp);
    host_valid = 1; host_we = 0; host_addr = a;
    tick();
    host_valid = 0;
  endtask

  task automatic h2_op(input logic we, input logic [7:0] a, input logic [7:0] d);
    if (!we) q2.push_back(d);
    h2_valid = 1; h2_we = we; h2_addr = a; h2_wdata = d;
    tick();
    h2_valid = 0; h2_we = 0;
  endtask

  initial begin
    #1;
    chk("rst_running", running, 0);
    chk("rst_host_ready", host_ready, 0);
    chk("rst_rvalid", host_rvalid, 0);
    chk("rst_rdata", host_rdata, 0);
    chk("rst_addr_error", addr_error, 0);
    repeat (2) @(posedge clk);
    #1 reset = 0;
    #1 chk("load_host_ready", host_ready, 1);
    // preload operands, the zero-filled store target and the ownership probe word
    for (int i = 0; i < 6; i++) host_wr(8'(i), 8'(8'h10 + i));
    for (int i = 0; i < 6; i++) host_wr(8'(8'h20 + i), 8'h00);
    host_wr(8'h40, 8'h00);
    // CPU store ignored in LOAD; end_flag ignored in LOAD
    address = 32'h40; write_data = {6{8'hFF}}; mem_write = 1; end_flag = 1;
    tick();
    mem_write = 0; end_flag = 0;
    chk("load_end_flag_ignored", running, 0);
    chk("load_store_ignored", read_data[0], 8'h00);
    host_rd(8'h40, 8'h00);
    // DEPTH=200 instance: in-range write/read, then an out-of-range read
    h2_op(1, 8'd199, 8'h99);
    h2_op(0, 8'd199, 8'h99);
    chk("h2_err_before", err2, 0);
    h2_op(0, 8'd210, 8'h00);
    chk("h2_err_after", err2, 1);
    // start into RUN
    address = 32'h0; start = 1;
    tick();
    start = 0;
    chk("run_running", running, 1);
    chk("run_host_ready", host_ready, 0);
    chk("preload_vec", read_data, 48'h151413121110);
    // CPU store; read_data shows old value until the edge
    address = 32'h20; write_data = 48'hA5A4A3A2A1A0; mem_write = 1;
    #1 chk("store_old_visible", read_data, 48'h0);
    tick();
    mem_write = 0;
    chk("store_new_visible", read_data, 48'hA5A4A3A2A1A0);
    // host blocked in RUN; start while running is ignored
    host_valid = 1; host_we = 0; host_addr = 8'h00; start = 1;
    repeat (3) tick();
    chk("run_host_blocked", host_ready, 0);
    host_valid = 0; start = 0;
    chk("run_start_ignored", running, 1);
    // end_flag together with a store; start concurrently loses to end_flag
    address = 32'h30; write_data = 48'h5F5E5D5C5B5A; mem_write = 1; end_flag = 1; start = 1;
    tick();
    mem_write = 0; end_flag = 0; start = 0;
    chk("done_running", running, 0);
    chk("done_host_ready", host_ready, 1);
    host_rd(8'h30, 8'h5A);
    for (int i = 0; i < 6; i++) host_rd(8'(8'h20 + i), 8'(8'hA0 + i));
    // start together with a host write in DONE
    host_valid = 1; host_we = 1; host_addr = 8'h50; host_wdata = 8'h77; start = 1; address = 32'h50;
    tick();
    host_valid = 0; host_we = 0; start = 0;
    chk("restart_running", running, 1);
    chk("restart_host_ready", host_ready, 0);
    chk("restart_host_write", read_data[0], 8'h77);
    // boundary store at 253
    chk("bound_err_before", addr_error, 0);
    address = 32'd253; write_data = 48'h060504030201; mem_write = 1;
    tick();
    mem_write = 0;
    chk("bound_err_after", addr_error, 1);
    chk("bound_read", read_data, 48'h000000030201);
    // asynchronous reset mid-cycle while running
    @(posedge clk);
    #3 reset = 1;
    #1;
    chk("mid_rst_running", running, 0);
    chk("mid_rst_rvalid", host_rvalid, 0);
    chk("mid_rst_addr_error", addr_error, 0);
    chk("mid_rst_host_ready", host_ready, 0);
    #10 reset = 0;
    tick();
    chk("post_rst_running", running, 0);
    chk("post_rst_host_ready", host_ready, 1);
    host_rd(8'h20, 8'hA0);
    host_rd(8'h30, 8'h5A);
    host_rd(8'hFD, 8'h01);
    host_rd(8'hFF, 8'h03);
    host_rd(8'h05, 8'h15);
    host_rd(8'h50, 8'h77);
    for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) tick();
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
